// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and address-decode field width for the APB master bridge.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    localparam int SEL_W = 3;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles and flags the last allowed one; MAX=0 never expires.
module apb_timeout_cnt #(
    parameter int MAX = 16
)(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = MAX > 1 ? $clog2(MAX) : 1;
    logic [CW-1:0] r_cnt;
    // Flag rises during the MAX-th enabled cycle so the transfer ends on that edge.
    assign o_expire = (MAX > 0) && (r_cnt == CW'(MAX - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expire)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding request port to APB master with address decode,
// per-slave select and ACCESS timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      TRANSFER,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_write,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);
    apb_state_e        r_state;
    logic [SEL_W-1:0]  w_idx;
    logic              w_bad, w_rdy, w_err, w_expire;
    logic [DATA_W-1:0] w_rdata;

    assign w_idx = req_addr[ADDR_W-1 -: SEL_W];
    assign w_bad = int'(w_idx) >= NUM_SLV;
    // The one-hot PSEL doubles as the mux select for the completing slave.
    assign w_rdy = |(PREADY & PSEL);
    assign w_err = |(PSLVERR & PSEL);
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++)
            w_rdata |= PSEL[i] ? PRDATA[i*DATA_W +: DATA_W] : '0;
    end

    apb_timeout_cnt #(.MAX(TIMEOUT)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state == SETUP),
        .i_en     (r_state == ACCESS),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (TRANSFER) begin
                    if (w_bad) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        r_state   <= SETUP;
                        req_ready <= 1'b0;
                        PSEL      <= NUM_SLV'(1) << w_idx;
                        PADDR     <= req_addr;
                        PWRITE    <= req_write;
                        PWDATA    <= req_wdata;
                        PSTRB     <= req_write ? req_strb : '0;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: if (w_rdy || w_expire) begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                    PSEL      <= '0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= w_rdy ? w_err : 1'b1;
                    rsp_rdata <= (w_rdy && !PWRITE) ? w_rdata : '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench with a behavioural APB slave for apb_master_bridge.
module tb_apb_master_bridge;
    localparam int AW = 32, DW = 32, NS = 4, TO = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk = 1'b0, rst, TRANSFER = 1'b0, req_ready, req_write = 1'b0;
    logic rsp_valid, rsp_err, PENABLE, PWRITE;
    logic [AW-1:0] req_addr = '0, PADDR;
    logic [DW-1:0] req_wdata = '0, rsp_rdata, PWDATA;
    logic [DW/8-1:0] req_strb = '0, PSTRB;
    logic [NS-1:0] PSEL, PREADY = '0, PSLVERR = '0;
    logic [NS*DW-1:0] PRDATA = '0;

    int checks = 0, failures = 0, cyc = 0, pen_cnt = 0, acc_cyc = 0, slv_wait = 0;
    bit never_rdy = 0, slv_err = 0, psel_any = 0;
    logic [NS-1:0] last_psel = '0;
    logic [AW-1:0] last_paddr = '0;
    logic [DW-1:0] last_pwdata = '0;
    logic [DW/8-1:0] last_pstrb = '0;
    logic last_pwrite = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .TRANSFER(TRANSFER), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Slave: ready after slv_wait stalled ACCESS cycles; PSLVERR is noisy while stalled.
    always @(negedge clk) begin
        if (PENABLE) begin
            acc_cyc++;
            PREADY  = (!never_rdy && acc_cyc > slv_wait) ? PSEL : '0;
            PSLVERR = (PREADY != 0) ? (slv_err ? PSEL : '0) : '1;
        end else begin
            acc_cyc = 0;
            PREADY  = '0;
            PSLVERR = '0;
        end
    end

    always @(negedge clk) begin
        if (PENABLE) pen_cnt++;
        if (PSEL != 0) begin
            psel_any = 1;
            if (!PENABLE) begin
                last_psel = PSEL; last_paddr = PADDR; last_pwdata = PWDATA;
                last_pstrb = PSTRB; last_pwrite = PWRITE;
            end
        end
        if (rsp_valid) begin
            if (sb.size() == 0) check("rsp_unexp", 64'(rsp_valid), 64'd0);
            else begin
                mon_e = sb.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                check("rsp_cyc", 64'(cyc), 64'(mon_e.cyc));
                check("rsp_ready", 64'(req_ready), 64'd1);
            end
        end
    end

    task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s, input bit push, input logic [DW-1:0] er,
                       input logic ee, input int lat);
        int n = 0;
        @(negedge clk); #1;
        while (!req_ready && n < 200) begin @(negedge clk); #1; n++; end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        pen_cnt = 0; psel_any = 0;
        req_addr = a; req_write = w; req_wdata = d; req_strb = s; TRANSFER = 1'b1;
        if (push) sb.push_back('{rdata: er, err: ee, cyc: cyc + lat});
        @(negedge clk); #1;
        TRANSFER = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rv;
        rst = 1'b1;
        PRDATA = {32'hBAD3_0003, 32'hBAD2_0002, 32'hBAD1_0001, 32'hBAD0_0000};
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;

        req(32'h2000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1'b0, 3);
        drain();
        check("wr_psel", 64'(last_psel), 64'b0010);
        check("wr_paddr", 64'(last_paddr), 64'h2000_0010);
        check("wr_pwdata", 64'(last_pwdata), 64'hDEAD_BEEF);
        check("wr_pstrb", 64'(last_pstrb), 64'hF);
        check("wr_pwrite", 64'(last_pwrite), 64'd1);
        check("wr_pen_cnt", 64'(pen_cnt), 64'd1);

        PRDATA[2*DW +: DW] = 32'h1234_5678;
        slv_wait = 3;
        req(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b0, 6);
        TRANSFER = 1'b1; req_addr = 32'h6000_0040; req_write = 1'b1;
        repeat (3) @(negedge clk);
        #1 TRANSFER = 1'b0;
        drain();
        check("rd_pen_cnt", 64'(pen_cnt), 64'd4);
        check("rd_psel", 64'(last_psel), 64'b0100);
        check("rd_pstrb", 64'(last_pstrb), 64'd0);
        check("rd_paddr_hold", 64'(PADDR), 64'h4000_0000);
        check("rd_psel_off", 64'(PSEL), 64'd0);

        slv_wait = 0;
        req(32'h8000_0000, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b1, 1);
        drain();
        check("dec_psel", 64'(psel_any), 64'd0);
        check("dec_pen_cnt", 64'(pen_cnt), 64'd0);

        never_rdy = 1;
        req(32'h0000_0004, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b1, 2 + TO);
        drain();
        check("tmo_pen_cnt", 64'(pen_cnt), 64'(TO));
        never_rdy = 0;

        slv_wait = TO - 1;
        req(32'h0000_0008, 1'b0, 32'h0, 4'h0, 1, 32'hBAD0_0000, 1'b0, 2 + TO);
        drain();
        check("tmo_edge_pen_cnt", 64'(pen_cnt), 64'(TO));

        slv_wait = 0; slv_err = 1;
        req(32'h6000_0020, 1'b1, 32'hCAFE_F00D, 4'h3, 1, 32'h0, 1'b1, 3);
        drain();
        check("err_psel", 64'(last_psel), 64'b1000);
        check("err_pstrb", 64'(last_pstrb), 64'h3);
        slv_err = 0;

        slv_wait = 5;
        req(32'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
        @(negedge clk);
        check("abort_in_access", 64'(PENABLE), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_psel", 64'(PSEL), 64'd0);
        check("abort_penable", 64'(PENABLE), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        rv = 0;
        repeat (8) begin @(negedge clk); #1; rv += int'(rsp_valid); end
        check("abort_no_rsp", 64'(rv), 64'd0);

        slv_wait = 0;
        PRDATA[1*DW +: DW] = 32'h0BAD_CAFE;
        req(32'h2000_0100, 1'b0, 32'h0, 4'h0, 1, 32'h0BAD_CAFE, 1'b0, 3);
        drain();
        check("post_rst_psel", 64'(last_psel), 64'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
